id_ex_pipeline_reg: RTL and testbench

- ID/EX pipeline register. It captures decoded operands, register indices and control from the ID stage, and presents them to the EX stage.
- Its ex_rs1_data and ex_rs2_data outputs are the "no-forwarding" inputs (Data_ID) of the EX-stage forwarding muxes.
- It supports stall (hold) and flush (bubble insertion), and has a built-in write-back write-through. This keeps EX operands correct when the register file is written in the same cycle they are read, or while EX is stalled.

---
 rtl/id_ex_pipeline_reg.sv | 187 ++++++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
//
// ID/EX pipeline register. It captures the decoded operands, the register
// indices and the control bits from ID, and presents them to EX one cycle
// later. ex_rs1_data and ex_rs2_data feed the "no-forwarding" leg of the EX
// forwarding muxes.
//
// Per-edge priority: rst > flush > stall > load.
//   rst            : all outputs cleared.
//   flush          : bubble (all outputs 0, ex_valid=0).
//   stall          : contents held, but a WB write to a held source register
//                    is written through into the held operand data.
//   load, id_valid : capture ID, with WB write-through on the captured data.
//   load, !id_valid: bubble, exactly as flush.
// Register x0 is never written through.
//
// Optional feature (macro ID_EX_BUBBLE_CNT_EN):
//   adds output bubble_count, a wrapping 32-bit count of the edges on which
//   a bubble is written (flush, or a load with id_valid=0), cleared by rst.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             hazard-unit controls
//   id_*                     decoded instruction from ID
//   wb_reg_write, wb_rd,
//   wb_data                  register-file write port from WB
//   ex_*                     registered copies presented to EX
//   bubble_count             bubble counter (only with ID_EX_BUBBLE_CNT_EN)
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,

    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_reg_write,
    input  logic                id_mem_to_reg,

    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data,

`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]         bubble_count,
`endif

    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_rs1_data,
    output logic [XLEN-1:0]     ex_rs2_data,
    output logic [XLEN-1:0]     ex_imm,
    output logic [REG_AW-1:0]   ex_rs1,
    output logic [REG_AW-1:0]   ex_rs2,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_reg_write,
    output logic                ex_mem_to_reg
);

    // The whole EX-side state is one struct, so a bubble or reset is a
    // single '0 and a hold is a single copy.
    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
    } ex_stage_t;

    ex_stage_t ex_q;
    ex_stage_t ex_d;

    // WB write-through hits. x0 is hard-wired zero, so a WB "write" to it
    // must never leak into an operand.
    logic wb_active;
    logic hit_id_rs1;
    logic hit_id_rs2;
    logic hit_ex_rs1;
    logic hit_ex_rs2;

    assign wb_active  = wb_reg_write && (wb_rd != '0);
    assign hit_id_rs1 = wb_active && (wb_rd == id_rs1);
    assign hit_id_rs2 = wb_active && (wb_rd == id_rs2);
    assign hit_ex_rs1 = wb_active && (wb_rd == ex_q.rs1);
    assign hit_ex_rs2 = wb_active && (wb_rd == ex_q.rs2);

    // A bubble is written on flush, or on a load slot with nothing valid.
    logic bubble;
    assign bubble = flush || (!stall && !id_valid);

    always_comb begin
        // NOTE: defaulting ex_d before any branch makes every path assign it,
        // so no latch is inferred for the fields a branch leaves untouched.
        ex_d = ex_q;
        if (bubble) begin
            ex_d = '0;
        end else if (stall) begin
            if (hit_ex_rs1) ex_d.rs1_data = wb_data;
            if (hit_ex_rs2) ex_d.rs2_data = wb_data;
        end else begin
            ex_d.valid      = 1'b1;
            ex_d.pc         = id_pc;
            ex_d.rs1_data   = hit_id_rs1 ? wb_data : id_rs1_data;
            ex_d.rs2_data   = hit_id_rs2 ? wb_data : id_rs2_data;
            ex_d.imm        = id_imm;
            ex_d.rs1        = id_rs1;
            ex_d.rs2        = id_rs2;
            ex_d.rd         = id_rd;
            ex_d.alu_op     = id_alu_op;
            ex_d.alu_src    = id_alu_src;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_to_reg = id_mem_to_reg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    // Wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (bubble) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bubble_count = bubble_cnt_q;
`endif

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipeline_reg
//
// Directed test-plan steps followed by a randomized run. A reference model
// of "what EX holds" is advanced once per clock edge from the stated rules
// and every DUT output is compared against it after each edge.
// Define ID_EX_BUBBLE_CNT_EN to also cover bubble_count.
// ---------------------------------------------------------------------------
module tb_id_ex_pipeline_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef ID_EX_BUBBLE_CNT_EN
        .bubble_count(bubble_count),
`endif
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg)
    );

    // Reference model: the instruction EX is expected to hold.
    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    } ex_model_t;

    ex_model_t   m;
    logic [31:0] m_bubbles;

    function automatic ex_model_t empty_slot();
        ex_model_t e;
        e.valid = 0; e.pc = 0; e.rs1_data = 0; e.rs2_data = 0; e.imm = 0;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.alu_op = 0;
        e.alu_src = 0; e.mem_read = 0; e.mem_write = 0; e.reg_write = 0;
        e.mem_to_reg = 0;
        return e;
    endfunction

    // The value register r holds once this cycle's WB write lands.
    function automatic logic [31:0] regval(input logic [4:0] r, input logic [31:0] read_data);
        if (wb_reg_write && r != 0 && wb_rd == r) return wb_data;
        return read_data;
    endfunction

    // Apply the rules for the coming edge to the model.
    task automatic model_edge();
        if (rst) begin
            m = empty_slot();
            m_bubbles = 0;
        end else if (flush || (!stall && !id_valid)) begin
            m = empty_slot();
            m_bubbles = m_bubbles + 1;
        end else if (stall) begin
            m.rs1_data = regval(m.rs1, m.rs1_data);
            m.rs2_data = regval(m.rs2, m.rs2_data);
        end else begin
            m.valid = 1; m.pc = id_pc; m.imm = id_imm;
            m.rs1_data = regval(id_rs1, id_rs1_data);
            m.rs2_data = regval(id_rs2, id_rs2_data);
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.alu_op = id_alu_op;
            m.alu_src = id_alu_src; m.mem_read = id_mem_read;
            m.mem_write = id_mem_write; m.reg_write = id_reg_write;
            m.mem_to_reg = id_mem_to_reg;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, " ex_valid"},      32'(ex_valid),      32'(m.valid));
        chk({step, " ex_pc"},         ex_pc,              m.pc);
        chk({step, " ex_rs1_data"},   ex_rs1_data,        m.rs1_data);
        chk({step, " ex_rs2_data"},   ex_rs2_data,        m.rs2_data);
        chk({step, " ex_imm"},        ex_imm,             m.imm);
        chk({step, " ex_rs1"},        32'(ex_rs1),        32'(m.rs1));
        chk({step, " ex_rs2"},        32'(ex_rs2),        32'(m.rs2));
        chk({step, " ex_rd"},         32'(ex_rd),         32'(m.rd));
        chk({step, " ex_alu_op"},     32'(ex_alu_op),     32'(m.alu_op));
        chk({step, " ex_alu_src"},    32'(ex_alu_src),    32'(m.alu_src));
        chk({step, " ex_mem_read"},   32'(ex_mem_read),   32'(m.mem_read));
        chk({step, " ex_mem_write"},  32'(ex_mem_write),  32'(m.mem_write));
        chk({step, " ex_reg_write"},  32'(ex_reg_write),  32'(m.reg_write));
        chk({step, " ex_mem_to_reg"}, 32'(ex_mem_to_reg), 32'(m.mem_to_reg));
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({step, " bubble_count"},  bubble_count,       m_bubbles);
`endif
    endtask

    // Advance one edge: update the model from the inputs now applied, let the
    // edge happen, then sample 1 time unit later and compare everything.
    task automatic tick(input string step);
        model_edge();
        @(posedge clk);
        #1;
        check_all(step);
    endtask

    task automatic rand_id();
        id_valid      = 1'b1;
        id_pc         = $urandom;
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm        = $urandom;
        id_rs1        = 5'($urandom_range(0, 3));
        id_rs2        = 5'($urandom_range(0, 3));
        id_rd         = 5'($urandom);
        id_alu_op     = 4'($urandom);
        id_alu_src    = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_reg_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
    endtask

    task automatic wb_off();
        wb_reg_write = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'd0;
    endtask

    initial begin
        logic [31:0] cnt_before;
        m = empty_slot();
        m_bubbles = 0;
        rst = 1; stall = 0; flush = 0;
        rand_id();
        wb_off();

        // Reset: everything zero.
        tick("reset0");
        tick("reset1");
        chk("reset ex_valid", 32'(ex_valid), 32'd0);
        rst = 0;

        // Basic load.
        rand_id();
        id_rs1 = 5'd1; id_rs2 = 5'd2;
        id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_rd = 5'd5; id_reg_write = 1;
        tick("basic");
        chk("basic rs1_data", ex_rs1_data, 32'h11);
        chk("basic rs2_data", ex_rs2_data, 32'h22);
        chk("basic rd", 32'(ex_rd), 32'd5);
        chk("basic valid", 32'(ex_valid), 32'd1);

        // Capture write-through.
        rand_id();
        id_rs1 = 5'd7; id_rs1_data = 32'hAAAA; id_rs2 = 5'd2;
        wb_reg_write = 1; wb_rd = 5'd7; wb_data = 32'h1234;
        tick("wt_cap");
        chk("wt_cap rs1_data", ex_rs1_data, 32'h1234);
        // x0 is never written through.
        rand_id();
        id_rs1 = 5'd0; id_rs1_data = 32'hAAAA;
        wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h1234;
        tick("wt_x0");
        chk("wt_x0 rs1_data", ex_rs1_data, 32'hAAAA);
        // rs1 == rs2 both take the write-through value.
        rand_id();
        id_rs1 = 5'd9; id_rs2 = 5'd9;
        wb_reg_write = 1; wb_rd = 5'd9; wb_data = 32'hBEEF;
        tick("wt_same");
        chk("wt_same rs1_data", ex_rs1_data, 32'hBEEF);
        chk("wt_same rs2_data", ex_rs2_data, 32'hBEEF);
        wb_off();

        // Stall hold with write-through on a held operand.
        rand_id();
        id_rs1 = 5'd4; id_rs2 = 5'd3; id_rs2_data = 32'h5; id_rd = 5'd12;
        tick("st_load");
        stall = 1;
        rand_id();
        tick("st_c1");
        chk("st_c1 rs2_data", ex_rs2_data, 32'h5);
        rand_id();
        wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'h99;
        tick("st_c2");
        chk("st_c2 rs2_data", ex_rs2_data, 32'h99);
        wb_off();
        rand_id();
        tick("st_c3");
        chk("st_c3 rs2_data", ex_rs2_data, 32'h99);
        chk("st_c3 rd", 32'(ex_rd), 32'd12);

        // Flush beats stall.
        cnt_before = m_bubbles;
        flush = 1;
        tick("flush_stall");
        chk("flush_stall valid", 32'(ex_valid), 32'd0);
        chk("flush_stall reg_write", 32'(ex_reg_write), 32'd0);
        chk("flush_stall rd", 32'(ex_rd), 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("flush_stall count", bubble_count, cnt_before + 32'd1);
`endif
        flush = 0; stall = 0;

        // id_valid=0 bubble with nonzero fields.
        rand_id();
        tick("pre_bubble");
        rand_id();
        id_valid = 0; id_rd = 5'd17; id_reg_write = 1; id_mem_write = 1;
        tick("idv0");
        chk("idv0 valid", 32'(ex_valid), 32'd0);
        chk("idv0 pc", ex_pc, 32'd0);

        // Reset together with stall after a valid load.
        rand_id();
        tick("pre_rst");
        rst = 1; stall = 1;
        rand_id();
        tick("rst_stall");
        chk("rst_stall valid", 32'(ex_valid), 32'd0);
        chk("rst_stall rs1_data", ex_rs1_data, 32'd0);
        rst = 0; stall = 0;

        // Randomized run.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            id_valid     = ($urandom_range(0, 9) < 7);
            stall        = ($urandom_range(0, 9) < 3);
            flush        = ($urandom_range(0, 9) < 1);
            rst          = ($urandom_range(0, 49) == 0);
            wb_reg_write = 1'($urandom);
            wb_rd        = 5'($urandom_range(0, 3));
            wb_data      = $urandom;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
